// File: rtl/alu_pkg.sv
// Shared ALU op codes and arbiter state encoding.
package alu_pkg;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_XOR = 3'b100;
  localparam logic [2:0] ALU_NOT = 3'b101;
  localparam logic [2:0] ALU_INC = 3'b110;
  localparam logic [2:0] ALU_DEC = 3'b111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_e;

endpackage

// File: rtl/nBit_ALU.sv
// Combinational n-bit ALU; carry doubles as borrow for subtract/decrement.
module nBit_ALU
  import alu_pkg::*;
#(
  parameter int unsigned n = 4
) (
  input  logic [n-1:0] a,
  input  logic [n-1:0] b,
  input  logic [2:0]   mode,
  output logic [n-1:0] result_c,
  output logic         carry_c
);

  logic [n:0] ext;

  always_comb begin
    ext      = '0;
    result_c = '0;
    carry_c  = 1'b0;
    case (mode)
      ALU_ADD: begin
        ext      = {1'b0, a} + {1'b0, b};
        result_c = ext[n-1:0];
        carry_c  = ext[n];
      end
      ALU_SUB: begin
        result_c = a - b;
        carry_c  = (a < b);
      end
      ALU_AND: result_c = a & b;
      ALU_OR:  result_c = a | b;
      ALU_XOR: result_c = a ^ b;
      ALU_NOT: result_c = ~a;
      ALU_INC: begin
        ext      = {1'b0, a} + (n+1)'(1);
        result_c = ext[n-1:0];
        carry_c  = ext[n];
      end
      ALU_DEC: begin
        result_c = a - n'(1);
        carry_c  = (a == '0);
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/alu_share_arbiter.sv
// Round-robin sharing of one ALU between two valid/ready requesters,
// with a registered, ID-tagged response held until the consumer accepts it.
module alu_share_arbiter
  import alu_pkg::*;
#(
  parameter int unsigned N = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         req0_valid,
  output logic         req0_ready,
  input  logic [N-1:0] req0_a,
  input  logic [N-1:0] req0_b,
  input  logic [2:0]   req0_mode,
  input  logic         req1_valid,
  output logic         req1_ready,
  input  logic [N-1:0] req1_a,
  input  logic [N-1:0] req1_b,
  input  logic [2:0]   req1_mode,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic         rsp_id,
  output logic [N-1:0] rsp_result,
  output logic         rsp_carry
);

  state_e       state_q, state_d;
  logic         last_grant_q, last_grant_d;
  logic [N-1:0] a_q, a_d, b_q, b_d;
  logic [2:0]   mode_q, mode_d;
  logic         id_q, id_d;
  logic         rsp_valid_q, rsp_valid_d;
  logic         rsp_id_q, rsp_id_d;
  logic [N-1:0] rsp_result_q, rsp_result_d;
  logic         rsp_carry_q, rsp_carry_d;
  logic         grant0, grant1;
  logic [N-1:0] alu_result;
  logic         alu_carry;

  nBit_ALU #(.n(N)) u_alu (
    .a        (a_q),
    .b        (b_q),
    .mode     (mode_q),
    .result_c (alu_result),
    .carry_c  (alu_carry)
  );

  // Next-state, arbitration and handshake outputs.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    a_d          = a_q;
    b_d          = b_q;
    mode_d       = mode_q;
    id_d         = id_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_id_d     = rsp_id_q;
    rsp_result_d = rsp_result_q;
    rsp_carry_d  = rsp_carry_q;
    req0_ready   = 1'b0;
    req1_ready   = 1'b0;
    // A tie goes to whichever requester was not granted last.
    grant0 = req0_valid && (!req1_valid || last_grant_q);
    grant1 = req1_valid && (!req0_valid || !last_grant_q);
    case (state_q)
      IDLE: begin
        // Readies are forced low while reset is held so nothing looks accepted.
        req0_ready = grant0 && rst_n;
        req1_ready = grant1 && rst_n;
        if (grant0 || grant1) begin
          state_d      = EXEC;
          id_d         = grant1;
          last_grant_d = grant1;
          a_d          = grant1 ? req1_a    : req0_a;
          b_d          = grant1 ? req1_b    : req0_b;
          mode_d       = grant1 ? req1_mode : req0_mode;
        end
      end
      EXEC: begin
        state_d      = RESP;
        rsp_valid_d  = 1'b1;
        rsp_id_d     = id_q;
        rsp_result_d = alu_result;
        rsp_carry_d  = alu_carry;
      end
      RESP: begin
        if (rsp_ready) begin
          state_d     = IDLE;
          rsp_valid_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      a_q          <= '0;
      b_q          <= '0;
      mode_q       <= '0;
      id_q         <= 1'b0;
      rsp_valid_q  <= 1'b0;
      rsp_id_q     <= 1'b0;
      rsp_result_q <= '0;
      rsp_carry_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      a_q          <= a_d;
      b_q          <= b_d;
      mode_q       <= mode_d;
      id_q         <= id_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_id_q     <= rsp_id_d;
      rsp_result_q <= rsp_result_d;
      rsp_carry_q  <= rsp_carry_d;
    end
  end

  assign rsp_valid  = rsp_valid_q;
  assign rsp_id     = rsp_id_q;
  assign rsp_result = rsp_result_q;
  assign rsp_carry  = rsp_carry_q;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Bench for alu_share_arbiter: directed corner cases plus random traffic
// against an arithmetic model of the ALU and round-robin grant.
module tb_alu_share_arbiter;

  localparam int unsigned N = 4;
  localparam int M = 1 << N;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         req0_valid, req0_ready, req1_valid, req1_ready;
  logic [N-1:0] req0_a, req0_b, req1_a, req1_b;
  logic [2:0]   req0_mode, req1_mode;
  logic         rsp_valid, rsp_ready, rsp_id, rsp_carry;
  logic [N-1:0] rsp_result;

  int checks   = 0;
  int failures = 0;
  int last_win = 1;

  always #5 clk = ~clk;

  alu_share_arbiter #(.N(N)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req0_mode  (req0_mode),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .req1_mode  (req1_mode),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_id     (rsp_id),
    .rsp_result (rsp_result),
    .rsp_carry  (rsp_carry)
  );

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Returns carry*M + result, straight from the op definitions.
  function automatic int ref_alu(input int a, input int b, input int m);
    int r;
    int c;
    c = 0;
    case (m)
      0: begin r = a + b; c = (r >= M) ? 1 : 0; r = r % M; end
      1: begin c = (a < b) ? 1 : 0; r = (a - b + M) % M; end
      2: r = a & b;
      3: r = a | b;
      4: r = a ^ b;
      5: r = (M - 1) - a;
      6: begin r = a + 1; c = (r >= M) ? 1 : 0; r = r % M; end
      default: begin c = (a == 0) ? 1 : 0; r = (a + M - 1) % M; end
    endcase
    return c * M + r;
  endfunction

  task automatic chk_rsp_zero(input string tag);
    chk({tag, "_valid"},  int'(rsp_valid),  0);
    chk({tag, "_id"},     int'(rsp_id),     0);
    chk({tag, "_result"}, int'(rsp_result), 0);
    chk({tag, "_carry"},  int'(rsp_carry),  0);
  endtask

  task automatic scramble_inputs();
    req0_valid = 1'($urandom);
    req1_valid = 1'($urandom);
    req0_a     = N'($urandom);
    req0_b     = N'($urandom);
    req0_mode  = 3'($urandom);
    req1_a     = N'($urandom);
    req1_b     = N'($urandom);
    req1_mode  = 3'($urandom);
  endtask

  task automatic do_reset();
    rst_n      = 1'b0;
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    rsp_ready  = 1'b0;
    #1;
    chk("rst_ready0", int'(req0_ready), 0);
    chk("rst_ready1", int'(req1_ready), 0);
    chk_rsp_zero("rst");
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n    = 1'b1;
    last_win = 1;
    tick();
  endtask

  // One full transaction, starting in IDLE at posedge+1.
  task automatic do_txn(input int v0, input int v1, input int a0, input int b0, input int m0,
                        input int a1, input int b1, input int m1, input int hold);
    int win;
    int exp;
    req0_valid = 1'(v0);  req1_valid = 1'(v1);
    req0_a = N'(a0); req0_b = N'(b0); req0_mode = 3'(m0);
    req1_a = N'(a1); req1_b = N'(b1); req1_mode = 3'(m1);
    rsp_ready = 1'b0;
    #1;
    win = (v0 != 0 && v1 != 0) ? 1 - last_win : ((v1 != 0) ? 1 : 0);
    exp = (win == 1) ? ref_alu(a1, b1, m1) : ref_alu(a0, b0, m0);
    last_win = win;
    chk("grant_ready0", int'(req0_ready), (win == 0) ? 1 : 0);
    chk("grant_ready1", int'(req1_ready), (win == 1) ? 1 : 0);
    tick();
    scramble_inputs();
    #1;
    chk("exec_valid", int'(rsp_valid), 0);
    chk("exec_readies", int'({req0_ready, req1_ready}), 0);
    tick();
    chk("rsp_valid",  int'(rsp_valid),  1);
    chk("rsp_id",     int'(rsp_id),     win);
    chk("rsp_result", int'(rsp_result), exp % M);
    chk("rsp_carry",  int'(rsp_carry),  exp / M);
    for (int h = 0; h < hold; h++) begin
      scramble_inputs();
      #1;
      chk("hold_readies", int'({req0_ready, req1_ready}), 0);
      tick();
      chk("hold_valid",  int'(rsp_valid),  1);
      chk("hold_id",     int'(rsp_id),     win);
      chk("hold_result", int'(rsp_result), exp % M);
      chk("hold_carry",  int'(rsp_carry),  exp / M);
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    rsp_ready  = 1'b1;
    tick();
    rsp_ready = 1'b0;
    chk("post_hs_valid", int'(rsp_valid), 0);
  endtask

  initial begin
    rst_n = 1'b0;
    req0_a = '0; req0_b = '0; req0_mode = '0;
    req1_a = '0; req1_b = '0; req1_mode = '0;
    do_reset();

    // Reset while a transaction is in EXEC: it must vanish.
    req0_valid = 1'b1;
    req0_a = N'(9); req0_b = N'(3); req0_mode = 3'd0;
    #1;
    chk("pre_rst_ready0", int'(req0_ready), 1);
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_ready0", int'(req0_ready), 0);
    chk_rsp_zero("midrst");
    req0_valid = 1'b0;
    @(negedge clk);
    rst_n    = 1'b1;
    last_win = 1;
    tick();
    for (int i = 0; i < 5; i++) begin
      chk("post_rst_quiet", int'(rsp_valid), 0);
      tick();
    end
    do_txn(1, 0, 3, 4, 0, 0, 0, 0, 0);

    // Sustained ties from reset alternate 0,1,0,1.
    do_reset();
    for (int i = 0; i < 4; i++) begin
      do_txn(1, 1, $urandom_range(M - 1, 0), $urandom_range(M - 1, 0), $urandom_range(7, 0),
             $urandom_range(M - 1, 0), $urandom_range(M - 1, 0), $urandom_range(7, 0), 0);
      chk("tie_seq_id", int'(rsp_id), i % 2);
    end

    // Wrap and borrow corners.
    do_txn(1, 0, 15, 1, 0, 0, 0, 0, 0);
    do_txn(1, 0, 2, 5, 1, 0, 0, 0, 0);
    do_txn(1, 0, 0, 0, 7, 0, 0, 0, 0);
    do_txn(1, 0, 15, 0, 6, 0, 0, 0, 0);

    // Backpressure, then operand isolation on requester 1.
    do_txn(1, 1, 5, 6, 0, 7, 8, 1, 10);
    do_txn(0, 1, 0, 0, 0, 12, 10, 2, 0);

    // Requester 1 pulses while requester 0 sits in RESP, then re-presents.
    do_txn(1, 0, 9, 9, 4, 0, 0, 0, 3);
    do_txn(0, 1, 0, 0, 0, 6, 3, 3, 0);

    for (int i = 0; i < 40; i++) begin
      int v0;
      int v1;
      v0 = int'($urandom_range(1, 0));
      v1 = (v0 == 0) ? 1 : int'($urandom_range(1, 0));
      do_txn(v0, v1, $urandom_range(M - 1, 0), $urandom_range(M - 1, 0), $urandom_range(7, 0),
             $urandom_range(M - 1, 0), $urandom_range(M - 1, 0), $urandom_range(7, 0),
             $urandom_range(2, 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
